// File: rtl/fractal_sync_arbiter.sv
// Round-robin arbiter sharing one fractal sync node port among N_REQ local
// requesters. Requests are latched, issued downstream one at a time, and the
// node's wake is routed back only to the requester that was granted.

package fractal_sync_pkg;

    localparam int unsigned FSYNC_LVL_W = 2;
    localparam int unsigned FSYNC_ID_W  = 8;

    typedef struct packed {
        logic [FSYNC_LVL_W-1:0] lvl;
        logic [FSYNC_ID_W-1:0]  id;
    } fsync_sig_t;

    typedef struct packed {
        logic       sync;
        fsync_sig_t sig;
    } fsync_req_t;

    typedef struct packed {
        logic       wake;
        fsync_sig_t sig;
        logic       error;
    } fsync_rsp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

endpackage

// Handshake: there is no valid/ready back-pressure on any port. A request is a
// single-cycle req_i[i].sync pulse that is either latched (requester neither
// pending nor in flight) or answered next cycle with wake=1/error=1. Downstream,
// req_o.sync is a single-cycle pulse and the node answers with a single-cycle
// rsp_i.wake at any later cycle (or in the same cycle); each accepted request
// gets exactly one rsp_o[i].wake pulse unless a reset intervenes.
module fractal_sync_arbiter #(
    parameter type         fsync_req_t = fractal_sync_pkg::fsync_req_t,
    parameter type         fsync_rsp_t = fractal_sync_pkg::fsync_rsp_t,
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT     = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  fsync_req_t                   req_i [N_REQ],
    output fsync_rsp_t                   rsp_o [N_REQ],
    output fsync_req_t                   req_o,
    input  fsync_rsp_t                   rsp_i,
    output logic                         busy_o,
    output fractal_sync_pkg::arb_state_e state_o
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    fractal_sync_pkg::arb_state_e state_q;
    logic [N_REQ-1:0]             pend_q;
    fsync_req_t                   pend_req_q [N_REQ];
    logic [IDX_W-1:0]             ptr_q;
    logic [IDX_W-1:0]             gnt_q;
    logic [CNT_W-1:0]             cnt_q;
    fsync_req_t                   req_q;
    fsync_rsp_t                   rsp_q [N_REQ];

    logic                         in_flight;
    logic                         found;
    logic [IDX_W-1:0]             pick;
    int                           idx;

    assign in_flight = (state_q != fractal_sync_pkg::IDLE);

    // Round-robin pick: first pending requester at or after ptr_q, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = (int'(ptr_q) + k) % int'(N_REQ);
            if (!found && pend_q[IDX_W'(idx)]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    // Request latching, duplicate detection, arbitration FSM and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= fractal_sync_pkg::IDLE;
            pend_q  <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            req_q   <= '0;
            for (int i = 0; i < int'(N_REQ); i++) begin
                rsp_q[i]      <= '0;
                pend_req_q[i] <= '0;
            end
        end else begin
            req_q <= '0;

            // A pulse from a requester already pending or in flight is refused
            // with an error wake; otherwise it becomes pending.
            for (int i = 0; i < int'(N_REQ); i++) begin
                rsp_q[i] <= '0;
                if (req_i[i].sync) begin
                    if (pend_q[i] || (in_flight && (gnt_q == IDX_W'(i)))) begin
                        rsp_q[i].wake  <= 1'b1;
                        rsp_q[i].error <= 1'b1;
                    end else begin
                        pend_q[i]     <= 1'b1;
                        pend_req_q[i] <= req_i[i];
                    end
                end
            end

            case (state_q)
                fractal_sync_pkg::IDLE: begin
                    if (found) begin
                        gnt_q       <= pick;
                        pend_q[pick] <= 1'b0;
                        ptr_q       <= (pick == IDX_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
                        cnt_q       <= '0;
                        req_q.sync  <= 1'b1;
                        req_q.sig   <= pend_req_q[pick].sig;
                        state_q     <= fractal_sync_pkg::ISSUE;
                    end
                end

                fractal_sync_pkg::ISSUE,
                fractal_sync_pkg::WAIT: begin
                    // Completion is written after the duplicate loop so it wins
                    // when both target the granted requester in one cycle.
                    if (rsp_i.wake) begin
                        rsp_q[gnt_q].wake  <= 1'b1;
                        rsp_q[gnt_q].sig   <= rsp_i.sig;
                        rsp_q[gnt_q].error <= rsp_i.error;
                        state_q            <= fractal_sync_pkg::IDLE;
                    end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
                        // Node state is left as is; the error tells software.
                        rsp_q[gnt_q].wake  <= 1'b1;
                        rsp_q[gnt_q].error <= 1'b1;
                        rsp_q[gnt_q].sig   <= '0;
                        state_q            <= fractal_sync_pkg::IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= fractal_sync_pkg::WAIT;
                    end
                end

                default: begin
                    state_q <= fractal_sync_pkg::IDLE;
                end
            endcase
        end
    end

    assign rsp_o   = rsp_q;
    assign req_o   = req_q;
    assign busy_o  = in_flight;
    assign state_o = state_q;

endmodule

// File: tb/tb_fractal_sync_arbiter.sv
// Bench for fractal_sync_arbiter: directed scenarios followed by random traffic,
// predicted by a transaction-level model and checked by an independent monitor.

module tb_fractal_sync_arbiter;
  import fractal_sync_pkg::*;

  localparam int N     = 4;
  localparam int TMO   = 8;
  localparam int REQ_W = $bits(fsync_req_t);
  localparam int ST_W  = 16 + 1 + 2 + REQ_W + N + 1;
  localparam int RSP_W = 16 + 2 + FSYNC_LVL_W + FSYNC_ID_W + 1;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  fsync_req_t req [N];
  fsync_rsp_t rsp [N];
  fsync_req_t req_o;
  fsync_rsp_t rsp_i;
  logic       busy;
  arb_state_e st;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fractal_sync_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .rsp_o   (rsp),
    .req_o   (req_o),
    .rsp_i   (rsp_i),
    .busy_o  (busy),
    .state_o (st)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [RSP_W-1:0] exp_q[$];
  logic [ST_W-1:0]  exp_st_q[$];
  int               n_vec  = 0;
  int               n_fail = 0;
  bit               mon_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Abstract view: a set of pending requesters, at most one owner of the node
  // port with the number of cycles since its issue, and a rotating start index.
  bit         m_pend [N];
  fsync_sig_t m_sig  [N];
  int         m_owner = -1;
  int         m_age   = 0;
  int         m_ptr   = 0;

  task automatic model_step();
    int               nc;
    bit               granted;
    bit               new_pend [N];
    fsync_sig_t       new_sig  [N];
    logic [N-1:0]     rsp_has;
    logic [RSP_W-1:0] rsp_e [N];
    fsync_req_t       req_e;
    arb_state_e       st_e;
    nc      = cyc + 1;
    granted = 0;
    rsp_has = '0;
    req_e   = '0;
    st_e    = IDLE;
    for (int i = 0; i < N; i++) begin
      new_pend[i] = 0;
      new_sig[i]  = '0;
      rsp_e[i]    = '0;
    end
    if (rst) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_owner = -1;
      m_ptr   = 0;
      m_age   = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i].sync) begin
          if (m_pend[i] || m_owner == i) begin
            rsp_has[i] = 1'b1;
            rsp_e[i]   = {16'(nc), 2'(i), {FSYNC_LVL_W{1'b0}}, {FSYNC_ID_W{1'b0}}, 1'b1};
          end else begin
            new_pend[i] = 1;
            new_sig[i]  = req[i].sig;
          end
        end
      end
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (!granted && m_pend[c]) begin
            granted    = 1;
            m_owner    = c;
            m_pend[c]  = 0;
            m_ptr      = (c + 1) % N;
            m_age      = 0;
            req_e.sync = 1'b1;
            req_e.sig  = m_sig[c];
          end
        end
      end else begin
        if (rsp_i.wake) begin
          rsp_has[m_owner] = 1'b1;
          rsp_e[m_owner]   = {16'(nc), 2'(m_owner), rsp_i.sig.lvl, rsp_i.sig.id, rsp_i.error};
          m_owner          = -1;
        end else if (m_age == TMO) begin
          rsp_has[m_owner] = 1'b1;
          rsp_e[m_owner]   = {16'(nc), 2'(m_owner), {FSYNC_LVL_W{1'b0}}, {FSYNC_ID_W{1'b0}}, 1'b1};
          m_owner          = -1;
        end else begin
          m_age++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (new_pend[i]) begin
          m_pend[i] = 1;
          m_sig[i]  = new_sig[i];
        end
      end
      st_e = granted ? ISSUE : ((m_owner >= 0) ? WAIT : IDLE);
    end
    exp_st_q.push_back({16'(nc), (m_owner >= 0) && !rst, st_e, req_e, rsp_has, 1'b0});
    for (int i = 0; i < N; i++) if (rsp_has[i]) exp_q.push_back(rsp_e[i]);
  endtask

  // ---------------------------------------------------------------- monitor
  logic [ST_W-1:0]  mon_st;
  logic [ST_W-1:0]  mon_head;
  logic [RSP_W-1:0] mon_rsp;
  logic [RSP_W-1:0] mon_exp;
  logic [N-1:0]     mon_wv;
  logic             mon_stray;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_wv    = '0;
      mon_stray = 1'b0;
      for (int i = 0; i < N; i++) begin
        mon_wv[i] = rsp[i].wake;
        if (!rsp[i].wake && (rsp[i] != '0)) mon_stray = 1'b1;
      end
      mon_st = {16'(cyc), busy, st, req_o, mon_wv, mon_stray};
      if (exp_st_q.size() > 0) begin
        mon_head = exp_st_q[0];
        if (mon_head[ST_W-1 -: 16] == 16'(cyc)) begin
          void'(exp_st_q.pop_front());
          check("status", 64'(mon_st), 64'(mon_head));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (rsp[i].wake) begin
          mon_rsp = {16'(cyc), 2'(i), rsp[i].sig.lvl, rsp[i].sig.id, rsp[i].error};
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(mon_rsp), 64'd0);
          end else begin
            mon_exp = exp_q.pop_front();
            check("rsp", 64'(mon_rsp), 64'(mon_exp));
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  int         dmin     = 2;
  int         dmax     = 2;
  int         hang_pct = 0;
  int         err_pct  = 0;
  bit         node_act = 0;
  int         node_cnt = 0;
  fsync_sig_t node_sig = '0;

  // One cycle: the node reacts to the observed req_o, requesters pulse per mask.
  task automatic step(input bit do_rst, input logic [N-1:0] mask, input bit fixed,
                      input fsync_sig_t fsig, input bit force_wake);
    fsync_rsp_t rv;
    int         d;
    @(posedge clk);
    #1;
    rv = '0;
    if (req_o.sync) begin
      node_sig = req_o.sig;
      if (int'($urandom_range(99)) < hang_pct) begin
        node_act = 0;
      end else begin
        d = int'($urandom_range(dmax, dmin));
        if (d == 0) begin
          rv.wake  = 1'b1;
          node_act = 0;
        end else begin
          node_act = 1;
          node_cnt = d;
        end
      end
    end else if (node_act) begin
      node_cnt--;
      if (node_cnt == 0) begin
        rv.wake  = 1'b1;
        node_act = 0;
      end
    end
    if (rv.wake) begin
      rv.sig   = node_sig;
      rv.error = (int'($urandom_range(99)) < err_pct);
    end
    if (force_wake) begin
      rv.wake    = 1'b1;
      rv.sig.lvl = FSYNC_LVL_W'($urandom);
      rv.sig.id  = FSYNC_ID_W'($urandom);
      rv.error   = 1'($urandom_range(1));
    end
    if (do_rst) begin
      rv       = '0;
      node_act = 0;
    end
    rst   = do_rst;
    rsp_i = rv;
    for (int i = 0; i < N; i++) begin
      req[i].sync = mask[i];
      if (fixed) req[i].sig = fsig;
      else begin
        req[i].sig.lvl = FSYNC_LVL_W'($urandom);
        req[i].sig.id  = FSYNC_ID_W'($urandom);
      end
    end
    model_step();
    mon_en = 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, 0, '0, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  fsync_sig_t s;
  logic [N-1:0] rmask;

  initial begin
    rst   = 1'b1;
    rsp_i = '0;
    for (int i = 0; i < N; i++) req[i] = '0;

    // reset state
    for (int k = 0; k < 3; k++) step(1, '0, 0, '0, 0);
    idle(2);

    // single requester 2, id 1, node wakes two cycles after issue
    dmin = 2; dmax = 2; hang_pct = 0; err_pct = 0;
    s.lvl = '0; s.id = 8'd1;
    step(0, 4'b0100, 1, s, 0);
    idle(8);

    // simultaneous 0,1,3 from ptr 0, then 3 again after its response
    step(1, '0, 0, '0, 0);
    step(0, 4'b1011, 0, '0, 0);
    idle(14);
    step(0, 4'b1000, 0, '0, 0);
    idle(8);

    // duplicate from requester 1 while waiting
    dmin = 6; dmax = 6;
    step(0, 4'b0010, 0, '0, 0);
    idle(2);
    step(0, 4'b0010, 0, '0, 0);
    idle(8);

    // timeout: node never wakes, second pending requester issued after abort
    hang_pct = 100;
    step(0, 4'b0101, 0, '0, 0);
    idle(26);
    hang_pct = 0;

    // wake in the ISSUE cycle
    dmin = 0; dmax = 0; err_pct = 50;
    step(0, 4'b0001, 0, '0, 0);
    idle(2);
    step(0, 4'b1010, 0, '0, 0);
    idle(6);

    // reset mid-WAIT with others pending, then a stray wake in IDLE
    dmin = 10; dmax = 10;
    step(0, 4'b0001, 0, '0, 0);
    idle(3);
    step(0, 4'b0110, 0, '0, 0);
    idle(2);
    step(1, '0, 0, '0, 0);
    idle(3);
    step(0, '0, 0, '0, 1);
    idle(5);

    // random traffic
    dmin = 0; dmax = 5; hang_pct = 4; err_pct = 25;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) rmask[i] = (int'($urandom_range(99)) < 15);
      step(($urandom_range(299) == 0), rmask, 0, '0, ($urandom_range(49) == 0));
    end

    // drain
    hang_pct = 0; dmin = 1; dmax = 3;
    idle(30);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rsp_left", 64'(exp_q.size()), 64'd0);
    check("status_left", 64'(exp_st_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
